// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg: shared state encoding and default step period for the countdown timer
package countdown_timer_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;
  localparam int DEF_DIV_COUNT = 12000000;
endpackage

// File: rtl/countdown_timer_tick_gen.sv
// tick_gen: prescaler producing a one-cycle enable strobe every DIV_COUNT enabled cycles
module tick_gen
  import countdown_timer_pkg::*;
#(
  parameter int DIV_COUNT = DEF_DIV_COUNT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int PW = $clog2(DIV_COUNT);
  logic [PW-1:0] cnt;
  assign tick = en && (cnt == PW'(DIV_COUNT - 1));
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter stepping once per DIV_COUNT cycles, raising done at zero
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int DIV_COUNT = DEF_DIV_COUNT,
  parameter int WIDTH     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] led,
  output logic             running,
  output logic             expired,
  output logic             done
);
  state_t state;
  logic   is_run, en, clr, tick;
  assign is_run  = state == ST_RUN;
  assign running = is_run;
  assign expired = state == ST_DONE;
  // A pause in RUN freezes the prescaler on that very cycle; start from IDLE restarts it.
  assign en  = is_run && !pause;
  assign clr = (load && !is_run) || (start && state == ST_IDLE);
  tick_gen #(.DIV_COUNT(DIV_COUNT)) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (clr),
    .tick(tick)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      led   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load && !is_run) begin
        led   <= load_val;
        state <= ST_IDLE;
      end else if (pause && is_run) begin
        state <= ST_PAUSED;
      end else if (start && state == ST_IDLE) begin
        state <= (led != '0) ? ST_RUN : ST_DONE;
        done  <= led == '0;
      end else if (start && state == ST_PAUSED) begin
        state <= ST_RUN;
      end else if (tick) begin
        led <= led - 1'b1;
        if (led == WIDTH'(1)) begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
      end
    end
  end
endmodule
